// File: rtl/invader_fleet_if.sv
// ============================================================================
//  Module      : invader_fleet_if
//  Description : Frame/laser inputs and formation outputs of invader_fleet.
//                master = the side driving frame and laser state,
//                slave  = the fleet itself.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface invader_fleet_if #(
    parameter int NUM_INV = 6
) ();
    logic               frame;
    logic               laser_active;
    logic [9:0]         laser_x;
    logic [9:0]         laser_y;
    logic [9:0]         invaders_x;
    logic [9:0]         invaders_y;
    logic [NUM_INV-1:0] alive;
    logic [NUM_INV-1:0] invader_collision;
    logic               laser_hit;
    logic               all_dead;
    logic               reached_bottom;

    modport master (
        output frame, laser_active, laser_x, laser_y,
        input  invaders_x, invaders_y, alive, invader_collision,
        input  laser_hit, all_dead, reached_bottom
    );

    modport slave (
        input  frame, laser_active, laser_x, laser_y,
        output invaders_x, invaders_y, alive, invader_collision,
        output laser_hit, all_dead, reached_bottom
    );
endinterface

`default_nettype wire

// File: rtl/invader_fleet.sv
// ============================================================================
//  Module      : invader_fleet
//  Description : Single-row invader formation. Once per frame it scans every
//                invader against the laser (one invader per cycle, lowest
//                index wins, at most one kill per frame), then spends one
//                cycle pulsing the hit and marching the formation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module invader_fleet #(
    parameter int NUM_INV     = 6,
    parameter int INV_W       = 16,
    parameter int INV_H       = 16,
    parameter int SPACING     = 32,
    parameter int STEP_X      = 4,
    parameter int STEP_Y      = 16,
    parameter int MOVE_FRAMES = 8,
    parameter int START_X     = 64,
    parameter int START_Y     = 40,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 639,
    parameter int BOTTOM_Y    = 400,
    parameter int LASER_W     = 2,
    parameter int LASER_H     = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    invader_fleet_if.slave    fleet
);

    localparam int c_idx_w  = (NUM_INV > 1) ? $clog2(NUM_INV) : 1;
    localparam int c_fcnt_w = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;

    // Geometry constants, all 11 bits wide so that sums never wrap.
    localparam logic [10:0] c_inv_w      = 11'(INV_W);
    localparam logic [10:0] c_inv_h      = 11'(INV_H);
    localparam logic [10:0] c_spacing    = 11'(SPACING);
    localparam logic [10:0] c_laser_w    = 11'(LASER_W);
    localparam logic [10:0] c_laser_h    = 11'(LASER_H);
    localparam logic [10:0] c_step_x11   = 11'(STEP_X);
    localparam logic [10:0] c_form_w     = 11'((NUM_INV - 1) * SPACING + INV_W);
    localparam logic [10:0] c_x_lim      = 11'(X_MAX + 1);
    localparam logic [10:0] c_x_min_step = 11'(X_MIN + STEP_X);
    localparam logic [10:0] c_bottom     = 11'(BOTTOM_Y);

    localparam logic [9:0]  c_step_x10   = 10'(STEP_X);
    localparam logic [9:0]  c_step_y10   = 10'(STEP_Y);
    localparam logic [9:0]  c_start_x    = 10'(START_X);
    localparam logic [9:0]  c_start_y    = 10'(START_Y);

    localparam logic [c_idx_w-1:0]  c_last_idx  = c_idx_w'(NUM_INV - 1);
    localparam logic [c_fcnt_w-1:0] c_fcnt_last = c_fcnt_w'(MOVE_FRAMES - 1);
    localparam logic [NUM_INV-1:0]  c_one_hot0  = NUM_INV'(1);

    localparam logic [1:0] c_st_wait = 2'd0;
    localparam logic [1:0] c_st_scan = 2'd1;
    localparam logic [1:0] c_st_move = 2'd2;

    logic [1:0]          r_state;
    logic [c_idx_w-1:0]  r_idx;
    logic [c_idx_w-1:0]  r_hit_idx;
    logic                r_hit_found;
    logic [c_fcnt_w-1:0] r_fcnt;
    logic                r_dir_left;
    logic [9:0]          r_x;
    logic [9:0]          r_y;
    logic [NUM_INV-1:0]  r_alive;
    logic [NUM_INV-1:0]  r_coll;
    logic                r_laser_hit;
    logic                r_reached;

    logic [10:0] w_ix;
    logic [10:0] w_iy;
    logic [10:0] w_lx;
    logic [10:0] w_ly;
    logic        w_overlap;
    logic        w_hit;
    logic        w_all_dead;
    logic        w_right_blocked;
    logic        w_left_blocked;
    logic [9:0]  w_y_down;
    logic        w_y_down_bottom;

    // Hitbox of the invader currently being scanned, versus the laser box.
    assign w_ix      = {1'b0, r_x} + 11'(r_idx) * c_spacing;
    assign w_iy      = {1'b0, r_y};
    assign w_lx      = {1'b0, fleet.laser_x};
    assign w_ly      = {1'b0, fleet.laser_y};
    assign w_overlap = (w_lx < w_ix + c_inv_w) && (w_lx + c_laser_w > w_ix) &&
                       (w_ly < w_iy + c_inv_h) && (w_ly + c_laser_h > w_iy);
    assign w_hit     = fleet.laser_active && r_alive[r_idx] && !r_hit_found && w_overlap;

    // Edge tests use the full formation width, dead invaders included.
    assign w_all_dead      = (r_alive == '0);
    assign w_right_blocked = ({1'b0, r_x} + c_step_x11 + c_form_w) > c_x_lim;
    assign w_left_blocked  = {1'b0, r_x} < c_x_min_step;
    assign w_y_down        = r_y + c_step_y10;
    assign w_y_down_bottom = ({1'b0, w_y_down} + c_inv_h) >= c_bottom;

    // Frame sequencer: WAIT for frame, SCAN each invader, MOVE for one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_st_wait;
            r_idx       <= '0;
            r_hit_idx   <= '0;
            r_hit_found <= 1'b0;
            r_fcnt      <= '0;
            r_dir_left  <= 1'b0;
            r_x         <= c_start_x;
            r_y         <= c_start_y;
            r_alive     <= '1;
            r_coll      <= '0;
            r_laser_hit <= 1'b0;
            r_reached   <= 1'b0;
        end else begin
            // Hit outputs are single-cycle pulses; only MOVE raises them.
            r_coll      <= '0;
            r_laser_hit <= 1'b0;
            case (r_state)
                c_st_wait: begin
                    if (fleet.frame) begin
                        r_state     <= c_st_scan;
                        r_idx       <= '0;
                        r_hit_found <= 1'b0;
                    end
                end
                c_st_scan: begin
                    if (w_hit) begin
                        r_alive[r_idx] <= 1'b0;
                        r_hit_found    <= 1'b1;
                        r_hit_idx      <= r_idx;
                    end
                    if (r_idx == c_last_idx) begin
                        r_state <= c_st_move;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                c_st_move: begin
                    r_state <= c_st_wait;
                    if (r_hit_found) begin
                        r_coll      <= c_one_hot0 << r_hit_idx;
                        r_laser_hit <= 1'b1;
                    end
                    // A wiped-out or landed formation stops marching entirely.
                    if (!w_all_dead && !r_reached) begin
                        if (r_fcnt == c_fcnt_last) begin
                            r_fcnt <= '0;
                            if (!r_dir_left) begin
                                if (w_right_blocked) begin
                                    r_y        <= w_y_down;
                                    r_dir_left <= 1'b1;
                                    r_reached  <= w_y_down_bottom;
                                end else begin
                                    r_x <= r_x + c_step_x10;
                                end
                            end else begin
                                if (w_left_blocked) begin
                                    r_y        <= w_y_down;
                                    r_dir_left <= 1'b0;
                                    r_reached  <= w_y_down_bottom;
                                end else begin
                                    r_x <= r_x - c_step_x10;
                                end
                            end
                        end else begin
                            r_fcnt <= r_fcnt + 1'b1;
                        end
                    end
                end
                default: r_state <= c_st_wait;
            endcase
        end
    end

    assign fleet.invaders_x        = r_x;
    assign fleet.invaders_y        = r_y;
    assign fleet.alive             = r_alive;
    assign fleet.invader_collision = r_coll;
    assign fleet.laser_hit         = r_laser_hit;
    assign fleet.all_dead          = w_all_dead;
    assign fleet.reached_bottom    = r_reached;

endmodule

`default_nettype wire

// File: tb/tb_invader_fleet.sv
// ============================================================================
//  Module      : tb_invader_fleet
//  Description : Self-checking bench for invader_fleet. dut1 uses default
//                parameters; dut2 lowers the invasion line to 80 so that a
//                landing happens within a reasonable number of frames.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_invader_fleet;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    invader_fleet_if #(.NUM_INV(6)) if1 ();
    invader_fleet_if #(.NUM_INV(6)) if2 ();

    invader_fleet dut1 (.clk(clk), .rst(rst), .fleet(if1));
    invader_fleet #(.BOTTOM_Y(80)) dut2 (.clk(clk), .rst(rst), .fleet(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference formation state, tracked frame by frame.
    typedef struct {
        int       x;
        int       y;
        bit       left;
        int       fcnt;
        bit [5:0] alive;
        bit       reached;
    } model_t;

    model_t m1;
    model_t m2;

    function automatic model_t model_init();
        model_t m;
        m.x = 64; m.y = 40; m.left = 0; m.fcnt = 0; m.alive = 6'h3f; m.reached = 0;
        return m;
    endfunction

    // One whole frame: pick the lowest live invader overlapping the laser,
    // kill it, then march if the formation is still in play. Returns hit index or -1.
    function automatic int model_frame(inout model_t m, input int bottom,
                                       input bit act, input int lx, input int ly);
        int hit;
        hit = -1;
        for (int i = 0; i < 6; i++) begin
            int ix;
            ix = m.x + i * 32;
            if (hit < 0 && act && m.alive[i] &&
                lx < ix + 16 && lx + 2 > ix && ly < m.y + 16 && ly + 8 > m.y)
                hit = i;
        end
        if (hit >= 0) m.alive[hit] = 1'b0;
        if (m.alive != 0 && !m.reached) begin
            m.fcnt = (m.fcnt + 1) % 8;
            if (m.fcnt == 0) begin
                if (!m.left) begin
                    if (m.x + 4 + 176 > 640) begin m.y += 16; m.left = 1; end
                    else m.x += 4;
                end else begin
                    if (m.x < 4) begin m.y += 16; m.left = 0; end
                    else m.x -= 4;
                end
                if (m.y + 16 >= bottom) m.reached = 1;
            end
        end
        return hit;
    endfunction

    function automatic logic [5:0] onehot(input int hit);
        logic [5:0] v;
        v = '0;
        if (hit >= 0) v[hit] = 1'b1;
        return v;
    endfunction

    task automatic set_laser(input bit act, input int lx, input int ly);
        if1.laser_active = act;
        if1.laser_x      = 10'(lx);
        if1.laser_y      = 10'(ly);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m1 = model_init();
        m2 = model_init();
    endtask

    // Pulse frame on one DUT, sample the pulse cycle (t+NUM_INV+2) and the cycle after.
    task automatic do_frame(input bit two, output logic [5:0] coll, output logic lh,
                            output logic [5:0] coll_after, output logic lh_after);
        @(negedge clk);
        if (two) if2.frame = 1'b1; else if1.frame = 1'b1;
        @(negedge clk);
        if1.frame = 1'b0;
        if2.frame = 1'b0;
        repeat (7) @(negedge clk);
        coll = two ? if2.invader_collision : if1.invader_collision;
        lh   = two ? if2.laser_hit : if1.laser_hit;
        @(negedge clk);
        coll_after = two ? if2.invader_collision : if1.invader_collision;
        lh_after   = two ? if2.laser_hit : if1.laser_hit;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (if1.invaders_x !== 10'd64) begin errors++; $display("FAIL reset_x got %0d want 64", if1.invaders_x); end
        checks++; if (if1.invaders_y !== 10'd40) begin errors++; $display("FAIL reset_y got %0d want 40", if1.invaders_y); end
        checks++; if (if1.alive !== 6'h3f) begin errors++; $display("FAIL reset_alive got %b want 111111", if1.alive); end
        checks++; if (if1.invader_collision !== 6'h00 || if1.laser_hit !== 1'b0) begin
            errors++; $display("FAIL reset_pulse got %b/%b want 0/0", if1.invader_collision, if1.laser_hit); end
        checks++; if (if1.all_dead !== 1'b0 || if1.reached_bottom !== 1'b0) begin
            errors++; $display("FAIL reset_flags got %b/%b want 0/0", if1.all_dead, if1.reached_bottom); end
        checks++; if (if2.reached_bottom !== 1'b0) begin errors++; $display("FAIL reset_bottom2 got %b want 0", if2.reached_bottom); end
        rst = 1'b1;
        m1 = model_init();
        m2 = model_init();
    endtask

    task automatic test_march();
        logic [5:0] c, ca;
        logic       l, la;
        apply_reset();
        set_laser(0, 0, 0);
        for (int f = 1; f <= 816; f++) begin
            void'(model_frame(m1, 400, 0, 0, 0));
            do_frame(0, c, l, ca, la);
            checks++;
            if (if1.invaders_x !== 10'(m1.x) || if1.invaders_y !== 10'(m1.y) || l !== 1'b0) begin
                errors++;
                $display("FAIL march frame %0d got x=%0d y=%0d hit=%b want x=%0d y=%0d hit=0",
                         f, if1.invaders_x, if1.invaders_y, l, m1.x, m1.y);
            end
            if (f == 800 || f == 808 || f == 816) begin
                int ex, ey;
                ex = (f == 816) ? 460 : 464;
                ey = (f == 800) ? 40 : 56;
                checks++;
                if (if1.invaders_x !== 10'(ex) || if1.invaders_y !== 10'(ey)) begin
                    errors++;
                    $display("FAIL march_mark frame %0d got x=%0d y=%0d want x=%0d y=%0d",
                             f, if1.invaders_x, if1.invaders_y, ex, ey);
                end
            end
        end
    endtask

    task automatic test_hit();
        logic [5:0] c, ca;
        logic       l, la;
        apply_reset();
        set_laser(1, 133, 45);
        void'(model_frame(m1, 400, 1, 133, 45));
        do_frame(0, c, l, ca, la);
        checks++; if (c !== 6'b000100 || l !== 1'b1) begin errors++; $display("FAIL hit_pulse got %b/%b want 000100/1", c, l); end
        checks++; if (ca !== 6'b0 || la !== 1'b0) begin errors++; $display("FAIL hit_one_cycle got %b/%b want 000000/0", ca, la); end
        checks++; if (if1.alive !== 6'b111011) begin errors++; $display("FAIL hit_alive got %b want 111011", if1.alive); end
        void'(model_frame(m1, 400, 1, 133, 45));
        do_frame(0, c, l, ca, la);
        checks++; if (c !== 6'b0 || l !== 1'b0) begin errors++; $display("FAIL hit_repeat got %b/%b want 000000/0", c, l); end
        checks++; if (if1.alive !== 6'(m1.alive)) begin errors++; $display("FAIL hit_repeat_alive got %b want %b", if1.alive, m1.alive); end
        set_laser(0, 0, 0);
    endtask

    task automatic test_edge();
        logic [5:0] c, ca;
        logic       l, la;
        int         h;
        apply_reset();
        set_laser(1, 79, 40);
        h = model_frame(m1, 400, 1, 79, 40);
        do_frame(0, c, l, ca, la);
        checks++; if (c !== onehot(h) || c !== 6'b000001) begin errors++; $display("FAIL edge_79 got %b want 000001", c); end
        apply_reset();
        set_laser(1, 80, 40);
        h = model_frame(m1, 400, 1, 80, 40);
        do_frame(0, c, l, ca, la);
        checks++; if (c !== onehot(h) || l !== 1'b0) begin errors++; $display("FAIL edge_80 got %b/%b want %b/0", c, l, onehot(h)); end
        checks++; if (if1.alive !== 6'h3f) begin errors++; $display("FAIL edge_80_alive got %b want 111111", if1.alive); end
        set_laser(0, 70, 40);
        h = model_frame(m1, 400, 0, 70, 40);
        do_frame(0, c, l, ca, la);
        checks++; if (c !== onehot(h) || l !== 1'b0 || if1.alive !== 6'h3f) begin
            errors++; $display("FAIL edge_inactive got %b/%b alive %b want 000000/0 alive 111111", c, l, if1.alive); end
    endtask

    task automatic test_kill_all();
        logic [5:0] c, ca;
        logic       l, la;
        int         h;
        logic [9:0] fx, fy;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            set_laser(1, 64 + 32 * i, 40);
            h = model_frame(m1, 400, 1, 64 + 32 * i, 40);
            do_frame(0, c, l, ca, la);
            checks++; if (c !== onehot(h) || l !== (h >= 0)) begin
                errors++; $display("FAIL kill_%0d got %b/%b want %b/%b", i, c, l, onehot(h), h >= 0); end
        end
        checks++; if (if1.all_dead !== 1'b1 || if1.alive !== 6'b0) begin
            errors++; $display("FAIL kill_all_dead got %b alive %b want 1 alive 000000", if1.all_dead, if1.alive); end
        set_laser(0, 0, 0);
        fx = if1.invaders_x;
        fy = if1.invaders_y;
        for (int f = 0; f < 16; f++) do_frame(0, c, l, ca, la);
        checks++; if (fx !== 10'(m1.x) || if1.invaders_x !== 10'(m1.x) || if1.invaders_y !== 10'(m1.y) || fy !== 10'(m1.y)) begin
            errors++; $display("FAIL kill_frozen got x=%0d y=%0d want x=%0d y=%0d", if1.invaders_x, if1.invaders_y, m1.x, m1.y); end
    endtask

    task automatic test_random();
        logic [5:0] c, ca;
        logic       l, la;
        int         h, lx, ly;
        bit         act;
        apply_reset();
        for (int f = 0; f < 80; f++) begin
            act = ($urandom_range(0, 3) != 0);
            lx  = $urandom_range(40, 260);
            ly  = $urandom_range(25, 65);
            set_laser(act, lx, ly);
            h = model_frame(m1, 400, act, lx, ly);
            do_frame(0, c, l, ca, la);
            checks++;
            if (c !== onehot(h) || l !== (h >= 0) || ca !== 6'b0 || la !== 1'b0 ||
                if1.alive !== 6'(m1.alive) || if1.invaders_x !== 10'(m1.x) || if1.invaders_y !== 10'(m1.y)) begin
                errors++;
                $display("FAIL random f%0d laser(%0b,%0d,%0d) got coll=%b hit=%b alive=%b x=%0d y=%0d want coll=%b hit=%b alive=%b x=%0d y=%0d",
                         f, act, lx, ly, c, l, if1.alive, if1.invaders_x, if1.invaders_y,
                         onehot(h), h >= 0, m1.alive, m1.x, m1.y);
            end
        end
        set_laser(0, 0, 0);
    endtask

    task automatic test_bottom();
        logic [5:0] c, ca;
        logic       l, la;
        apply_reset();
        for (int f = 1; f <= 1760; f++) begin
            void'(model_frame(m2, 80, 0, 0, 0));
            do_frame(1, c, l, ca, la);
            checks++;
            if (if2.reached_bottom !== m2.reached || if2.invaders_y !== 10'(m2.y) || if2.invaders_x !== 10'(m2.x)) begin
                errors++;
                $display("FAIL bottom frame %0d got rb=%b x=%0d y=%0d want rb=%b x=%0d y=%0d",
                         f, if2.reached_bottom, if2.invaders_x, if2.invaders_y, m2.reached, m2.x, m2.y);
            end
        end
        checks++; if (if2.reached_bottom !== 1'b1 || if2.invaders_y !== 10'd72 || if2.invaders_x !== 10'd0) begin
            errors++; $display("FAIL bottom_final got rb=%b x=%0d y=%0d want rb=1 x=0 y=72",
                               if2.reached_bottom, if2.invaders_x, if2.invaders_y); end
    endtask

    task automatic test_reset_abort();
        logic seen;
        apply_reset();
        set_laser(1, 133, 45);
        @(negedge clk); if1.frame = 1'b1;
        @(negedge clk); if1.frame = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        set_laser(0, 0, 0);
        checks++; if (if1.alive !== 6'h3f || if1.invaders_x !== 10'd64 || if1.invaders_y !== 10'd40) begin
            errors++; $display("FAIL abort_state got alive=%b x=%0d y=%0d want 111111 64 40",
                               if1.alive, if1.invaders_x, if1.invaders_y); end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (if1.invader_collision !== 6'b0 || if1.laser_hit !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0 || if1.alive !== 6'h3f) begin
            errors++; $display("FAIL abort_pulse got pulse_seen=%b alive=%b want 0 111111", seen, if1.alive); end
        m1 = model_init();
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b0;
        if1.frame        = 1'b0;
        if2.frame        = 1'b0;
        if2.laser_active = 1'b0;
        if2.laser_x      = 10'd0;
        if2.laser_y      = 10'd0;
        set_laser(0, 0, 0);
        test_reset();
        test_march();
        test_hit();
        test_edge();
        test_kill_all();
        test_random();
        test_bottom();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
